// File: rtl/comet_ram_ctrl.sv
// Parametrised program RAM controller for the COMET II memory bus: split read/write
// ports, configurable read latency, range checking and a constant-fill engine.
module comet_ram_ctrl #(
  parameter int unsigned       DATA_W     = 16,
  parameter int unsigned       ADDR_W     = 16,
  parameter int unsigned       DEPTH      = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter int unsigned       RD_LAT     = 1,
  parameter logic [DATA_W-1:0] FILL_VAL   = '0,
  parameter bit                INIT_CLEAR = 1'b1
) (
  input  logic              mclk,
  input  logic              rst,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              clr,
  output logic              busy,
  output logic              err
);

  localparam int unsigned       CNT_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0]  LAST    = CNT_W'(DEPTH - 1);

  typedef enum logic {S_IDLE, S_FILL} state_t;

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              w_fill_we;
  logic              w_idle;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [ADDR_W-1:0] w_roff, w_woff;
  logic              w_rin, w_win;
  logic              w_rd_acc, w_wr_ok, w_wr_bad;
  logic [DATA_W-1:0] w_rd_dat;

  logic [RD_LAT-1:0] r_pv, r_pe;
  logic [DATA_W-1:0] r_pd [RD_LAT];
  logic              r_werr;

  // Fill engine state register
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      r_state <= INIT_CLEAR ? S_FILL : S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_fill_we   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (clr) begin
          w_state_nxt = S_FILL;
          w_cnt_nxt   = '0;
        end
      end
      S_FILL: begin
        w_fill_we = 1'b1;
        if (r_cnt == LAST) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign busy   = (r_state == S_FILL);
  assign w_idle = (r_state == S_IDLE);

  // Offsets wrap modulo 2^ADDR_W, so addresses below BASE_ADDR land far out of range
  assign w_roff   = raddr - BASE_ADDR;
  assign w_woff   = waddr - BASE_ADDR;
  assign w_rin    = ({1'b0, w_roff} < DEPTH_L);
  assign w_win    = ({1'b0, w_woff} < DEPTH_L);
  assign w_rd_acc = re & w_idle;
  assign w_wr_ok  = we & w_idle & w_win;
  assign w_wr_bad = we & w_idle & ~w_win;

  always_comb begin
    w_rd_dat = '0;
    if (w_rin) begin
      if (w_wr_ok && (w_woff == w_roff))
        w_rd_dat = wdata;
      else
        w_rd_dat = r_mem[w_roff[CNT_W-1:0]];
    end
  end

  // Storage is deliberately not reset so it maps onto block RAM
  always_ff @(posedge mclk) begin
    if (w_fill_we)
      r_mem[r_cnt] <= FILL_VAL;
    else if (w_wr_ok)
      r_mem[w_woff[CNT_W-1:0]] <= wdata;
  end

  // Read pipeline: stage 0 captures at the sampling edge, last stage drives the outputs
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      r_pv   <= '0;
      r_pe   <= '0;
      r_werr <= 1'b0;
      for (int unsigned i = 0; i < RD_LAT; i++)
        r_pd[i] <= '0;
    end else begin
      r_pv[0] <= w_rd_acc;
      r_pe[0] <= w_rd_acc & ~w_rin;
      r_pd[0] <= w_rd_acc ? w_rd_dat : '0;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pe[i] <= r_pe[i-1];
        r_pd[i] <= r_pd[i-1];
      end
      r_werr <= w_wr_bad;
    end
  end

  assign rdata  = r_pd[RD_LAT-1];
  assign rvalid = r_pv[RD_LAT-1];
  assign err    = r_pe[RD_LAT-1] | r_werr;

endmodule

// File: doc/comet_ram_ctrl.md
# comet_ram_ctrl

Parametrised successor to the fixed-size program RAM on the COMET II CPU memory bus. It keeps the same split read/write port pair (`re/raddr/rdata`, `we/waddr/wdata`) and adds:
- configurable word width, depth, base address and read latency;
- a read-valid strobe and an out-of-range error strobe;
- a hardware fill engine that writes a constant to every word, after reset and on request.

It sits between `COMET_II_top` and on-chip block RAM; the CPU is held off while `busy` is high.

## Interface
Parameters:
- `DATA_W`, 16, word width in bits.
- `ADDR_W`, 16, bus address width.
- `DEPTH`, 256, number of words, 1..2^ADDR_W; need not be a power of two.
- `BASE_ADDR`, 16'h0000, bus address of word 0.
- `RD_LAT`, 1, read latency in cycles, legal 1..4.
- `FILL_VAL`, 0, value written by the fill engine.
- `INIT_CLEAR`, 1, 1 = run a fill automatically when reset is released.

Ports:
- `mclk`  in  1  system clock, single clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `re`  in  1  read request, sampled at the rising edge.
- `raddr`  in  ADDR_W  read address.
- `rdata`  out  DATA_W  read data.
- `rvalid`  out  1  `rdata` valid, one pulse per accepted read.
- `we`  in  1  write request.
- `waddr`  in  ADDR_W  write address.
- `wdata`  in  DATA_W  write data.
- `clr`  in  1  start a fill, one-cycle pulse.
- `busy`  out  1  fill in progress; `re`, `we` and `clr` are ignored while high.
- `err`  out  1  one-cycle pulse on an out-of-range access.

## Operation
- Address offset = (addr − BASE_ADDR) mod 2^ADDR_W. The address is in range iff offset < DEPTH.
- Fill engine states:
  - IDLE → FILL when `clr`=1.
  - FILL → IDLE after the write to offset DEPTH−1.
  - Reset enters FILL if INIT_CLEAR=1, otherwise IDLE.
- FILL behaviour:
  - The counter starts at 0 and writes FILL_VAL to one word per cycle, so a fill takes DEPTH cycles.
  - `busy`=1 throughout FILL.
  - `clr` during FILL is ignored; it does not restart the fill.
- Reads in IDLE:
  - An in-range `re` reads the word at the offset.
  - An out-of-range `re` returns 0 with `err`=1, aligned with its `rvalid`.
- Read pipeline:
  - Depth is RD_LAT.
  - Reads are accepted back-to-back, one per cycle.
  - Results return in issue order.
- Writes in IDLE:
  - An in-range `we` updates the word at the rising edge.
  - An out-of-range `we` is dropped and pulses `err` on the next cycle.
- Read and write to the same in-range offset in the same cycle: the read returns `wdata` (write-first).
- Simultaneous read error and write error in the same cycle: both are reported on one `err` line, and each strobe is kept at its own cycle. When two error strobes land on the same cycle, `err` is their OR.
- `we` and `clr` in the same IDLE cycle: the write is performed, then the fill starts on the next cycle and overwrites it.
- Reads already in the pipeline when a fill starts complete normally, with data captured at issue time.
- Reset:
  - Memory contents are not reset.
  - The pipeline, `rvalid`, `rdata` (0) and `err` (0) are cleared asynchronously.
  - `busy` = INIT_CLEAR.
  - The fill counter is set to 0.
  - A reset mid-fill aborts the fill. With INIT_CLEAR=1 it restarts from 0 after reset.

## Timing
- A read sampled at edge T produces `rdata`/`rvalid` (and any `err`) after edge T+RD_LAT−1, valid for exactly one cycle.
  - With RD_LAT=1 the result is visible in the cycle immediately after the request.
- A write sampled at edge T is visible to a read sampled at edge T (write-first) or later.
- Fill timing:
  - `busy` rises at the edge that samples `clr` (or asynchronously on reset when INIT_CLEAR=1).
  - `busy` falls at the edge that writes offset DEPTH−1.
  - A request made in the cycle after `busy` falls is accepted.
- Write `err` asserts after the edge that samples the bad `we`, for one cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset with INIT_CLEAR=1, DEPTH=256, FILL_VAL=16'hA5A5 → `busy`=1 for exactly 256 cycles after reset release; then reading 0x0000, 0x007F and 0x00FF returns A5A5.
- RD_LAT=3, write 0x1234 to 0x0010, then `re` on 0x0010 on three consecutive cycles → three `rvalid` pulses on consecutive cycles, each arriving 3 cycles after its request, each with `rdata`=0x1234.
- BASE_ADDR=0x0100, DEPTH=256, read 0x0200 and write 0x00FF → read returns 0 with `err`=1 aligned to `rvalid`; the write produces one `err` pulse and no memory change.
- Same-cycle `we` (0x0020 ← 0xBEEF) and `re` (0x0020) → `rdata`=0xBEEF.
- Pulse `clr` in IDLE with a read in flight (RD_LAT=2) → the in-flight read returns its old data; `busy` then stays high for DEPTH cycles; `re` and `we` during the fill produce no `rvalid` and no memory change.
- Assert `rst` midway through a fill (word 100 of 256) → outputs clear immediately; after release the fill restarts at offset 0 and `busy` lasts a full 256 cycles.
